// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter around the shared FP add/sub unit.
package fp_addsub_arbiter_pkg;

  localparam int MANT_W      = 11;
  localparam int EXP_W       = 5;
  localparam int REXP_W      = 6;
  localparam int ADD_LAT_MIN = 1;
  localparam int ADD_LAT_MAX = 4;
  localparam int CNT_W       = 3;
  localparam int LZC_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  // The seven operand fields of one request, latched as a unit at grant time
  typedef struct packed {
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic              sgn_a;
    logic              sgn_b;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic              op;
  } operand_t;

  // Leading-zero count of a mantissa; an all-zero input returns MANT_W
  function automatic logic [LZC_W-1:0] lzc(input logic [MANT_W-1:0] v);
    lzc = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (v[i]) lzc = LZC_W'(MANT_W - 1 - i);
    end
  endfunction

  // Out-of-range latencies are pulled back into the supported window
  function automatic int clamp_lat(input int lat);
    if (lat < ADD_LAT_MIN)      clamp_lat = ADD_LAT_MIN;
    else if (lat > ADD_LAT_MAX) clamp_lat = ADD_LAT_MAX;
    else                        clamp_lat = lat;
  endfunction

endpackage

// File: rtl/fp_addsub_arbiter_floatingptoper.sv
// Combinational sign-magnitude floating-point add/subtract on small mantissas.
// The larger-magnitude operand sets sign and exponent; the smaller one is
// right-aligned with truncation. Cancellation is renormalised, but never below exponent 0.
module floatingptoper
  import fp_addsub_arbiter_pkg::*;
(
  input  logic [MANT_W-1:0] i_mant_a,
  input  logic [MANT_W-1:0] i_mant_b,
  input  logic              i_sgn_a,
  input  logic              i_sgn_b,
  input  logic [EXP_W-1:0]  i_exp_a,
  input  logic [EXP_W-1:0]  i_exp_b,
  input  logic              i_op,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_sgn,
  output logic [REXP_W-1:0] o_exp
);

  logic              w_sgn_b_eff;
  logic              w_a_big;
  logic              w_sgn_big;
  logic [EXP_W-1:0]  w_exp_big;
  logic [EXP_W-1:0]  w_exp_diff;
  logic [MANT_W-1:0] w_mant_big;
  logic [MANT_W-1:0] w_mant_small;
  logic [MANT_W-1:0] w_mant_shift;
  logic [MANT_W:0]   w_sum;
  logic [MANT_W-1:0] w_diff;
  logic [LZC_W-1:0]  w_lz;

  // Align, add or subtract magnitudes, then normalise the result
  always_comb begin
    w_sgn_b_eff = i_sgn_b ^ i_op;
    w_a_big     = (i_exp_a > i_exp_b) || ((i_exp_a == i_exp_b) && (i_mant_a >= i_mant_b));
    if (w_a_big) begin
      w_sgn_big    = i_sgn_a;
      w_exp_big    = i_exp_a;
      w_exp_diff   = i_exp_a - i_exp_b;
      w_mant_big   = i_mant_a;
      w_mant_small = i_mant_b;
    end else begin
      w_sgn_big    = w_sgn_b_eff;
      w_exp_big    = i_exp_b;
      w_exp_diff   = i_exp_b - i_exp_a;
      w_mant_big   = i_mant_b;
      w_mant_small = i_mant_a;
    end
    w_mant_shift = w_mant_small >> w_exp_diff;
    w_sum        = {1'b0, w_mant_big} + {1'b0, w_mant_shift};
    w_diff       = w_mant_big - w_mant_shift;
    w_lz         = lzc(w_diff);
    o_mant       = '0;
    o_sgn        = 1'b0;
    o_exp        = '0;
    if (i_sgn_a == w_sgn_b_eff) begin
      o_sgn = w_sgn_big;
      if (w_sum[MANT_W]) begin
        o_mant = w_sum[MANT_W:1];
        o_exp  = {1'b0, w_exp_big} + REXP_W'(1);
      end else begin
        o_mant = w_sum[MANT_W-1:0];
        o_exp  = {1'b0, w_exp_big};
      end
    end else if (w_diff != '0) begin
      o_sgn = w_sgn_big;
      if ({1'b0, w_lz} <= w_exp_big) begin
        o_mant = w_diff << w_lz;
        o_exp  = {1'b0, w_exp_big - {1'b0, w_lz}};
      end else begin
        o_mant = w_diff << w_exp_big;
        o_exp  = '0;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter that shares one floatingptoper between two requesters.
// One operation is in flight at a time: grant, hold operands ADD_LAT cycles,
// capture, then hold the response until the consumer takes it.
module fp_addsub_arbiter
  import fp_addsub_arbiter_pkg::*;
#(
  parameter int ADD_LAT = 1
)
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [MANT_W-1:0] i_req0_mant_a,
  input  logic [MANT_W-1:0] i_req0_mant_b,
  input  logic              i_req0_sgn_a,
  input  logic              i_req0_sgn_b,
  input  logic [EXP_W-1:0]  i_req0_exp_a,
  input  logic [EXP_W-1:0]  i_req0_exp_b,
  input  logic              i_req0_op,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [MANT_W-1:0] i_req1_mant_a,
  input  logic [MANT_W-1:0] i_req1_mant_b,
  input  logic              i_req1_sgn_a,
  input  logic              i_req1_sgn_b,
  input  logic [EXP_W-1:0]  i_req1_exp_a,
  input  logic [EXP_W-1:0]  i_req1_exp_b,
  input  logic              i_req1_op,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [MANT_W-1:0] o_rsp_mant,
  output logic              o_rsp_sgn,
  output logic [REXP_W-1:0] o_rsp_exp,
  output logic              o_busy
);

  localparam int              LAT      = clamp_lat(ADD_LAT);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LAT);

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic [CNT_W-1:0]  r_cnt;
  operand_t          r_opnd;
  logic              r_id;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [MANT_W-1:0] r_rsp_mant;
  logic              r_rsp_sgn;
  logic [REXP_W-1:0] r_rsp_exp;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_grant;
  logic              w_capture;
  operand_t          w_req0;
  operand_t          w_req1;
  logic [MANT_W-1:0] w_add_mant;
  logic              w_add_sgn;
  logic [REXP_W-1:0] w_add_exp;

  assign w_req0 = {i_req0_mant_a, i_req0_mant_b, i_req0_sgn_a, i_req0_sgn_b,
                   i_req0_exp_a, i_req0_exp_b, i_req0_op};
  assign w_req1 = {i_req1_mant_a, i_req1_mant_b, i_req1_sgn_a, i_req1_sgn_b,
                   i_req1_exp_a, i_req1_exp_b, i_req1_op};

  // The adder only ever sees the latched operands, never the live request buses
  floatingptoper u_fpu (
    .i_mant_a (r_opnd.mant_a),
    .i_mant_b (r_opnd.mant_b),
    .i_sgn_a  (r_opnd.sgn_a),
    .i_sgn_b  (r_opnd.sgn_b),
    .i_exp_a  (r_opnd.exp_a),
    .i_exp_b  (r_opnd.exp_b),
    .i_op     (r_opnd.op),
    .o_mant   (w_add_mant),
    .o_sgn    (w_add_sgn),
    .o_exp    (w_add_exp)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; ISSUE ends when the down-counter reaches its last cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant) w_next = S_ISSUE;
      S_ISSUE:   if (r_cnt <= CNT_W'(1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    if (i_rsp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs and round-robin grant; grants are gated by reset so none leak out while it is held
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if ((r_state == S_IDLE) && i_rst_n) begin
      if (i_req0_valid && i_req1_valid) begin
        w_grant0 = r_last;
        w_grant1 = ~r_last;
      end else begin
        w_grant0 = i_req0_valid;
        w_grant1 = i_req1_valid;
      end
    end
    w_grant      = w_grant0 | w_grant1;
    w_capture    = (r_state == S_CAPTURE);
    o_req0_ready = w_grant0;
    o_req1_ready = w_grant1;
    o_busy       = (r_state != S_IDLE);
  end

  // Latch the winner's operands, update the pointer and run the issue counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_last <= 1'b1;
      r_opnd <= '0;
      r_id   <= 1'b0;
    end else if (w_grant) begin
      r_cnt  <= LAT_INIT;
      r_last <= w_grant1;
      r_id   <= w_grant1;
      r_opnd <= w_grant1 ? w_req1 : w_req0;
    end else if (r_state == S_ISSUE) begin
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  // Response registers: loaded in CAPTURE, held until the consumer accepts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_mant  <= '0;
      r_rsp_sgn   <= 1'b0;
      r_rsp_exp   <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp_mant  <= w_add_mant;
      r_rsp_sgn   <= w_add_sgn;
      r_rsp_exp   <= w_add_exp;
    end else if ((r_state == S_RESP) && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_mant  = r_rsp_mant;
  assign o_rsp_sgn   = r_rsp_sgn;
  assign o_rsp_exp   = r_rsp_exp;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter: a vector table of hand-computed
// results plus sequences for arbitration, back-pressure, reset and latency.
module tb_fp_addsub_arbiter;

  typedef struct {
    logic [10:0] mantA;
    logic [10:0] mantB;
    logic        sgnA;
    logic        sgnB;
    logic [4:0]  expA;
    logic [4:0]  expB;
    logic        op;
  } opnd_t;

  typedef struct {
    opnd_t       o;
    logic [10:0] mant;
    logic        sgn;
    logic [5:0]  exp;
  } vec_t;

  localparam int NV = 10;

  logic clk;
  logic rstN;
  logic r0Valid, r1Valid, rspReady;
  logic d4Valid0, d4Valid1, d4RspReady;
  opnd_t req0Op, req1Op;

  logic        ready0, ready1, rspValid, rspId, rspSgn, busy;
  logic [10:0] rspMant;
  logic [5:0]  rspExp;
  logic        d4Ready0, d4Ready1, d4RspValid, d4RspId, d4RspSgn, d4Busy;
  logic [10:0] d4RspMant;
  logic [5:0]  d4RspExp;

  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs[NV];
  vec_t vec35;

  fp_addsub_arbiter #(.ADD_LAT(1)) u_dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req0_valid(r0Valid), .o_req0_ready(ready0),
    .i_req0_mant_a(req0Op.mantA), .i_req0_mant_b(req0Op.mantB),
    .i_req0_sgn_a(req0Op.sgnA), .i_req0_sgn_b(req0Op.sgnB),
    .i_req0_exp_a(req0Op.expA), .i_req0_exp_b(req0Op.expB), .i_req0_op(req0Op.op),
    .i_req1_valid(r1Valid), .o_req1_ready(ready1),
    .i_req1_mant_a(req1Op.mantA), .i_req1_mant_b(req1Op.mantB),
    .i_req1_sgn_a(req1Op.sgnA), .i_req1_sgn_b(req1Op.sgnB),
    .i_req1_exp_a(req1Op.expA), .i_req1_exp_b(req1Op.expB), .i_req1_op(req1Op.op),
    .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_id(rspId),
    .o_rsp_mant(rspMant), .o_rsp_sgn(rspSgn), .o_rsp_exp(rspExp), .o_busy(busy)
  );

  fp_addsub_arbiter #(.ADD_LAT(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rstN),
    .i_req0_valid(d4Valid0), .o_req0_ready(d4Ready0),
    .i_req0_mant_a(req0Op.mantA), .i_req0_mant_b(req0Op.mantB),
    .i_req0_sgn_a(req0Op.sgnA), .i_req0_sgn_b(req0Op.sgnB),
    .i_req0_exp_a(req0Op.expA), .i_req0_exp_b(req0Op.expB), .i_req0_op(req0Op.op),
    .i_req1_valid(d4Valid1), .o_req1_ready(d4Ready1),
    .i_req1_mant_a(req1Op.mantA), .i_req1_mant_b(req1Op.mantB),
    .i_req1_sgn_a(req1Op.sgnA), .i_req1_sgn_b(req1Op.sgnB),
    .i_req1_exp_a(req1Op.expA), .i_req1_exp_b(req1Op.expB), .i_req1_op(req1Op.op),
    .o_rsp_valid(d4RspValid), .i_rsp_ready(d4RspReady), .o_rsp_id(d4RspId),
    .o_rsp_mant(d4RspMant), .o_rsp_sgn(d4RspSgn), .o_rsp_exp(d4RspExp), .o_busy(d4Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges despite its own bounds
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation still running, required finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int id, input opnd_t o, input logic valid);
    if (id == 0) begin
      req0Op  = o;
      r0Valid = valid;
    end else begin
      req1Op  = o;
      r1Valid = valid;
    end
  endtask

  function automatic opnd_t mkOp(input int ma, input int mb, input int sa, input int sb,
                                 input int ea, input int eb, input int op);
    opnd_t o;
    o.mantA = 11'(ma); o.mantB = 11'(mb);
    o.sgnA  = 1'(sa);  o.sgnB  = 1'(sb);
    o.expA  = 5'(ea);  o.expB  = 5'(eb);
    o.op    = 1'(op);
    return o;
  endfunction

  function automatic vec_t mkVec(input opnd_t o, input int m, input int s, input int e);
    vec_t v;
    v.o = o; v.mant = 11'(m); v.sgn = 1'(s); v.exp = 6'(e);
    return v;
  endfunction

  // One isolated operation on the ADD_LAT=1 instance, accepted as soon as it appears
  task automatic runOne(input int id, input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    rspReady = 1'b0;
    applyStimulus(id, v.o, 1'b1);
    #1;
    checkOutput({tag, "_ready"}, (id == 0) ? ready0 : ready1, 1);
    checkOutput({tag, "_otherReady"}, (id == 0) ? ready1 : ready0, 0);
    @(posedge clk); #1;
    r0Valid = 1'b0;
    r1Valid = 1'b0;
    cyc = 1;
    while (!rspValid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc, 3);
    checkOutput({tag, "_id"}, rspId, id);
    checkOutput({tag, "_result"}, {rspMant, rspSgn, rspExp}, {v.mant, v.sgn, v.exp});
    @(negedge clk);
    rspReady = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_done"}, {rspValid, busy}, 0);
    rspReady = 1'b0;
  endtask

  initial begin
    int cyc, nGrant, nResp, bad;
    int grantCyc[4];
    logic grantId[4];
    logic rspIdLog[4];
    logic [17:0] rspResLog[4];
    logic cleared;
    logic [17:0] res0, res1;
    int expOrder[4] = '{0, 1, 0, 1};

    vecs[0] = mkVec(mkOp(1536, 1540, 0, 0, 17, 11, 0), 1560, 0, 17);
    vecs[1] = mkVec(mkOp(2000, 1800, 1, 1, 12, 12, 0), 1900, 1, 13);
    vecs[2] = mkVec(mkOp(1024, 1023, 0, 0, 10, 10, 1), 1024, 0, 0);
    vecs[3] = mkVec(mkOp(1500, 1500, 0, 0, 5, 6, 1),   1500, 1, 5);
    vecs[4] = mkVec(mkOp(1234, 1234, 0, 0, 7, 7, 1),   0,    0, 0);
    vecs[5] = mkVec(mkOp(1024, 2047, 0, 0, 31, 0, 0),  1024, 0, 31);
    vecs[6] = mkVec(mkOp(2047, 2047, 0, 0, 31, 31, 0), 2047, 0, 32);
    vecs[7] = mkVec(mkOp(1600, 1200, 1, 1, 4, 4, 1),   1600, 1, 2);
    vecs[8] = mkVec(mkOp(1024, 1020, 0, 0, 1, 1, 1),   8,    0, 0);
    vecs[9] = mkVec(mkOp(1100, 1100, 0, 1, 2, 2, 1),   1100, 0, 3);
    vec35   = mkVec(mkOp(1897, 1200, 0, 0, 29, 29, 0), 1548, 0, 30);

    // Reset with requests already pending: nothing may be granted yet
    rstN = 1'b0; rspReady = 1'b0; d4RspReady = 1'b0;
    d4Valid0 = 1'b0; d4Valid1 = 1'b0;
    req0Op = vecs[0].o; req1Op = vecs[1].o;
    r0Valid = 1'b1; r1Valid = 1'b1;
    #22;
    checkOutput("resetState", {ready0, ready1, rspValid, rspId, rspMant, rspSgn, rspExp, busy}, 0);
    checkOutput("resetState4", {d4Ready0, d4Ready1, d4RspValid, d4RspId, d4RspMant, d4RspSgn, d4RspExp, d4Busy}, 0);
    r0Valid = 1'b0; r1Valid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    // Table of single operations, alternating requesters
    for (int i = 0; i < NV; i++) runOne(i % 2, vecs[i], $sformatf("v%0d", i));

    // Both requesters held valid for four operations with immediate acceptance
    @(negedge clk);
    req0Op = vecs[0].o; req1Op = vecs[1].o;
    r0Valid = 1'b1; r1Valid = 1'b1; rspReady = 1'b1;
    nGrant = 0; nResp = 0; cleared = 1'b0;
    for (int c = 0; c < 60 && nResp < 4; c++) begin
      #1;
      if (ready0 || ready1) begin
        if (nGrant < 4) begin
          grantId[nGrant] = ready1;
          grantCyc[nGrant] = c;
        end
        nGrant++;
      end
      if (rspValid) begin
        if (nResp < 4) begin
          rspIdLog[nResp] = rspId;
          rspResLog[nResp] = {rspMant, rspSgn, rspExp};
        end
        nResp++;
      end
      if (nGrant >= 4 && !cleared) begin
        @(posedge clk); #1;
        r0Valid = 1'b0; r1Valid = 1'b0;
        cleared = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("rrGrantCount", nGrant, 4);
    checkOutput("rrRespCount", nResp, 4);
    res0 = {vecs[0].mant, vecs[0].sgn, vecs[0].exp};
    res1 = {vecs[1].mant, vecs[1].sgn, vecs[1].exp};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rrGrant%0d", k), grantId[k], expOrder[k]);
      checkOutput($sformatf("rrRspId%0d", k), rspIdLog[k], expOrder[k]);
      checkOutput($sformatf("rrResult%0d", k), rspResLog[k], (expOrder[k] == 0) ? res0 : res1);
    end
    checkOutput("rrInterval", grantCyc[3] - grantCyc[2], 4);
    r0Valid = 1'b0; r1Valid = 1'b0; rspReady = 1'b0;
    repeat (3) @(negedge clk);

    // Back-pressure: response held ten cycles with both requesters still asking
    req0Op = vecs[0].o; req1Op = vecs[1].o;
    r0Valid = 1'b1; r1Valid = 1'b1; rspReady = 1'b0;
    #1;
    checkOutput("holdFirstGrant", {ready0, ready1}, 2'b10);
    cyc = 0;
    while (!rspValid && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (!rspValid || rspId !== 1'b0 || {rspMant, rspSgn, rspExp} !== res0 ||
          ready0 || ready1 || !busy) bad++;
    end
    checkOutput("holdStableCycles", bad, 0);
    rspReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("holdReleaseNextGrant", {ready0, ready1}, 2'b01);
    @(posedge clk); #1;
    r0Valid = 1'b0; r1Valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("holdDrained", busy, 0);
    rspReady = 1'b0;

    // Operands on req1 change right after grant; response must use the latched set
    @(negedge clk);
    applyStimulus(1, vec35.o, 1'b1);
    #1;
    checkOutput("latchReady1", ready1, 1);
    @(posedge clk); #1;
    r1Valid = 1'b0;
    @(posedge clk); #1;
    req1Op.mantA = 11'd1141;
    req1Op.expA  = 5'd29;
    cyc = 0;
    while (!rspValid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("latchId", rspId, 1);
    checkOutput("latchResult", {rspMant, rspSgn, rspExp}, {vec35.mant, vec35.sgn, vec35.exp});
    @(negedge clk);
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;

    // Reset pulse during ISSUE discards the operation and restores the pointer
    @(negedge clk);
    applyStimulus(0, vecs[2].o, 1'b1);
    @(posedge clk); #1;
    r1Valid = 1'b1;
    checkOutput("rstMidBusy", busy, 1);
    rstN = 1'b0;
    #1;
    checkOutput("rstMidOutputs", {ready0, ready1, rspValid, rspId, rspMant, rspSgn, rspExp, busy}, 0);
    @(posedge clk); #1;
    checkOutput("rstMidHeld", {ready0, ready1, rspValid, busy}, 0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rstFirstGrant", {ready0, ready1}, 2'b10);
    @(posedge clk); #1;
    r0Valid = 1'b0; r1Valid = 1'b0;
    cyc = 1;
    while (!rspValid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rstNewLatency", cyc, 3);
    checkOutput("rstNewResult", {rspId, rspMant, rspSgn, rspExp},
                {1'b0, vecs[2].mant, vecs[2].sgn, vecs[2].exp});
    @(negedge clk);
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;

    // ADD_LAT=4 instance: latency 6 and a grant spacing of 7
    @(negedge clk);
    req0Op = vecs[6].o; req1Op = vecs[7].o;
    d4Valid0 = 1'b1;
    #1;
    checkOutput("lat4Ready", d4Ready0, 1);
    @(posedge clk); #1;
    d4Valid0 = 1'b0;
    cyc = 1;
    while (!d4RspValid && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("lat4Latency", cyc, 6);
    checkOutput("lat4Result", {d4RspId, d4RspMant, d4RspSgn, d4RspExp},
                {1'b0, vecs[6].mant, vecs[6].sgn, vecs[6].exp});
    @(negedge clk);
    d4RspReady = 1'b1;
    @(negedge clk);
    d4Valid0 = 1'b1; d4Valid1 = 1'b1;
    nGrant = 0;
    for (int c = 0; c < 40 && nGrant < 2; c++) begin
      #1;
      if (d4Ready0 || d4Ready1) begin
        grantId[nGrant] = d4Ready1;
        grantCyc[nGrant] = c;
        nGrant++;
      end
      @(negedge clk);
    end
    d4Valid0 = 1'b0; d4Valid1 = 1'b0;
    checkOutput("lat4GrantCount", nGrant, 2);
    checkOutput("lat4Order", {grantId[0], grantId[1]}, 2'b10);
    checkOutput("lat4Interval", grantCyc[1] - grantCyc[0], 7);
    cyc = 0;
    while (d4Busy && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("lat4Drained", d4Busy, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 Parameter ADD_LAT, default 1, SHALL set the number of cycles operands are held on the shared adder before the result is captured (legal 1..4).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  grant pulse: operation from requester N accepted this cycle.
REQ-006 reqN_mant_a, reqN_mant_b  input  11  operand mantissas, hidden bit included.
REQ-007 reqN_sgn_a, reqN_sgn_b  input  1  operand signs.
REQ-008 reqN_exp_a, reqN_exp_b  input  5  operand exponents.
REQ-009 reqN_op  input  1  0 = add, 1 = subtract.
REQ-010 rsp_valid  output  1  result held on the response bus.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 rsp_mant  output  11, rsp_sgn  output  1, rsp_exp  output  6  registered adder result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL instantiate one shared floatingptoper and SHALL drive it only from internal operand registers.
REQ-016 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP.
REQ-017 IDLE: if any reqN_valid, the winner SHALL be granted, reqN_ready SHALL pulse high for exactly that cycle, its seven operand fields SHALL be latched, and the FSM SHALL go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 With one requester valid, that requester SHALL be granted regardless of the pointer; the pointer SHALL update on every grant.
REQ-020 ISSUE SHALL last exactly ADD_LAT cycles, counted by a down-counter; then CAPTURE.
REQ-021 CAPTURE SHALL register the adder outputs and the owning id into the rsp_* registers, assert rsp_valid next cycle and enter RESP.
REQ-022 RESP: rsp_valid and all rsp_* fields SHALL stay stable until rsp_ready is high; on that cycle the FSM SHALL return to IDLE and rsp_valid SHALL drop.
REQ-023 No grant SHALL occur outside IDLE; reqN_ready SHALL be 0 in ISSUE, CAPTURE and RESP.
REQ-024 Latency from grant to rsp_valid high SHALL be ADD_LAT+2 cycles; minimum issue interval SHALL be ADD_LAT+3 cycles.
REQ-025 Requester inputs changing after grant SHALL not affect the in-flight operation.
REQ-026 rsp_valid high with rsp_ready already high SHALL complete in one cycle.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_mant=0, rsp_sgn=0, rsp_exp=0, busy=0, counter=0, pointer=1.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight operation without producing a response.
REQ-029 The first grant after reset release SHALL happen no earlier than the first rising edge with rst_n high.

Structure
REQ-030 A shared package SHALL hold the state encoding, field widths (MANT_W=11, EXP_W=5, REXP_W=6) and the ADD_LAT legal range.
REQ-031 floatingptoper SHALL be the only sub-module; the arbiter and FSM SHALL be in this module.

Verification
REQ-032 Single request: req0 mant_a=1536, exp_a=17, mant_b=1540, exp_b=11, op=0, ADD_LAT=1 -> req0_ready one cycle, rsp_valid 3 cycles later, rsp_id=0, result equal to a standalone floatingptoper for the same inputs.
REQ-033 Simultaneous req0/req1 valid held for 4 operations -> grant order 0,1,0,1; rsp_id matches each grant.
REQ-034 rsp_ready held low 10 cycles -> rsp_* stable, no new grant, req0_ready/req1_ready stay 0.
REQ-035 Operand change on req1 one cycle after grant (mant_a 1897->1141, exp_a 29) -> response reflects the latched values 1897/29.
REQ-036 rst_n pulsed low during ISSUE -> all outputs at reset values immediately; after release, pending req0 granted first.
REQ-037 ADD_LAT=4 -> rsp_valid exactly 6 cycles after grant; back-to-back grants 7 cycles apart.
